// File: rtl/lisnoc_router_input_credit.sv
// Credit-based router input port: per-VC FIFO with stage bypass,
// header destination lookup, worm locking and protocol-error flags.
module lisnoc_router_input_credit #(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int ph_dest_width = 5,
   parameter int vchannels = 1,
   parameter int ports = 5,
   parameter int fifo_length = 4,
   parameter int num_dests = 1,
   parameter logic [ports*num_dests-1:0] lookup = '0,
   localparam int flit_width = flit_data_width + flit_type_width
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [flit_width-1:0]           link_flit,
   input  logic [vchannels-1:0]            link_valid,
   output logic [vchannels-1:0]            link_credit,
   output logic [ports*vchannels-1:0]      switch_request,
   output logic [flit_width*vchannels-1:0] switch_flit,
   input  logic [ports*vchannels-1:0]      switch_read,
   output logic [vchannels-1:0]            err_overflow,
   output logic [vchannels-1:0]            err_dest
);

   localparam int pw = $clog2(fifo_length);
   localparam int cw = $clog2(fifo_length + 1);

   localparam logic [flit_type_width-1:0] T_PAYLOAD = flit_type_width'(0);
   localparam logic [flit_type_width-1:0] T_HEADER  = flit_type_width'(1);
   localparam logic [flit_type_width-1:0] T_LAST    = flit_type_width'(2);
   localparam logic [flit_type_width-1:0] T_SINGLE  = flit_type_width'(3);

   typedef enum logic [1:0] {IDLE, ROUTED, DROP} state_t;

   logic [1:0] rst_sync;
   logic       rst_int;
   logic       multi;

   // Assert reset at once, release it two clocks after rst_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_int = rst_sync[1];
   assign multi = (link_valid & (link_valid - vchannels'(1))) != '0;

   for (genvar v = 0; v < vchannels; v++) begin : g_vc
      logic [flit_width-1:0]      mem [fifo_length];
      logic [pw-1:0]              rd_ptr, wr_ptr;
      logic [cw-1:0]              count;
      logic                       stage_valid;
      logic [flit_width-1:0]      stage_flit;
      state_t                     state, state_nxt;
      logic [ports-1:0]           dir, dir_nxt, lk, req, grant;
      logic [flit_type_width-1:0] stype;
      logic [ph_dest_width-1:0]   dest;
      logic dest_ok, xfer, consume, bad, depart;
      logic in_valid, full, accept, bypass, push, pop;
      logic credit, dest_err, ovf;

      assign grant = switch_read[v*ports +: ports];
      assign stype = stage_flit[flit_width-1 -: flit_type_width];
      assign dest = stage_flit[flit_data_width-1 -: ph_dest_width];

      // Map the stage destination onto its output direction
      always_comb begin
         lk = '0;
         dest_ok = 1'b0;
         for (int d = 0; d < num_dests; d++) begin
            if (dest == ph_dest_width'(d)) begin
               lk = lookup[(num_dests-d)*ports-1 -: ports];
               dest_ok = 1'b1;
            end
         end
      end

      // Route FSM: request, transfer, internal drop and next state
      always_comb begin
         state_nxt = state;
         dir_nxt = dir;
         req = '0;
         consume = 1'b0;
         bad = 1'b0;
         xfer = 1'b0;
         if (stage_valid) begin
            unique case (state)
               IDLE: begin
                  if (stype == T_HEADER || stype == T_SINGLE) begin
                     if (!dest_ok || lk == '0) begin
                        consume = 1'b1;
                        bad = !dest_ok;
                        if (stype == T_HEADER) state_nxt = DROP;
                     end else begin
                        req = lk;
                        xfer = (grant & lk) != '0;
                        if (xfer && stype == T_HEADER) begin
                           state_nxt = ROUTED;
                           dir_nxt = lk;
                        end
                     end
                  end else begin
                     consume = 1'b1;
                     bad = 1'b1;
                  end
               end
               ROUTED: begin
                  req = dir;
                  xfer = (grant & dir) != '0;
                  if (xfer && stype == T_LAST) state_nxt = IDLE;
               end
               DROP: begin
                  consume = 1'b1;
                  if (stype == T_LAST || stype == T_SINGLE)
                     state_nxt = IDLE;
               end
               default: state_nxt = IDLE;
            endcase
         end
      end

      assign depart = xfer | consume;
      assign in_valid = link_valid[v] & ~multi;
      assign full = stage_valid & (count == cw'(fifo_length));
      assign accept = in_valid & (~full | depart);
      assign pop = (count != '0) & (~stage_valid | depart);
      assign bypass = accept & (count == '0) & (~stage_valid | depart);
      assign push = accept & ~bypass;

      // FIFO storage, written only with accepted non-bypass flits
      always_ff @(posedge clk) begin
         if (push) mem[wr_ptr] <= link_flit;
      end

      // FIFO pointers and occupancy
      always_ff @(posedge clk or negedge rst_int) begin
         if (!rst_int) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
         end else begin
            if (push)
               wr_ptr <= (wr_ptr == pw'(fifo_length-1)) ? '0 : wr_ptr + pw'(1);
            if (pop)
               rd_ptr <= (rd_ptr == pw'(fifo_length-1)) ? '0 : rd_ptr + pw'(1);
            case ({push, pop})
               2'b10:   count <= count + cw'(1);
               2'b01:   count <= count - cw'(1);
               default: count <= count;
            endcase
         end
      end

      // Route stage refills from the FIFO head, else from the link
      always_ff @(posedge clk or negedge rst_int) begin
         if (!rst_int) begin
            stage_valid <= 1'b0;
            stage_flit <= '0;
         end else if (~stage_valid | depart) begin
            if (pop) begin
               stage_valid <= 1'b1;
               stage_flit <= mem[rd_ptr];
            end else if (bypass) begin
               stage_valid <= 1'b1;
               stage_flit <= link_flit;
            end else begin
               stage_valid <= 1'b0;
            end
         end
      end

      // FSM state, credit return and error flags
      always_ff @(posedge clk or negedge rst_int) begin
         if (!rst_int) begin
            state <= IDLE;
            dir <= '0;
            credit <= 1'b0;
            dest_err <= 1'b0;
            ovf <= 1'b0;
         end else begin
            state <= state_nxt;
            dir <= dir_nxt;
            credit <= depart;
            dest_err <= bad;
            if (link_valid[v] & (multi | (full & ~depart))) ovf <= 1'b1;
         end
      end

      assign link_credit[v] = credit;
      assign err_dest[v] = dest_err;
      assign err_overflow[v] = ovf;
      assign switch_request[v*ports +: ports] = req;
      assign switch_flit[v*flit_width +: flit_width] =
         stage_valid ? stage_flit : '0;
   end

endmodule

// File: doc/lisnoc_router_input_credit.md
Name: lisnoc_router_input_credit

Overview:
- Next-generation router input port. Replaces ready/valid link backpressure with credit-based flow control.
- Per virtual channel: a parametrised FIFO with empty-FIFO bypass into a route stage register, a header destination lookup, and worm locking until the LAST flit.
- Adds protocol-error detection for credit overflow and invalid destinations.
- Sits between the upstream link and the router switch/arbiters; one instance per router port.

Parameters:
- flit_data_width, 32, payload bits per flit.
- flit_type_width, 2, type bits (MSBs of flit): PAYLOAD=00, HEADER=01, LAST=10, SINGLE=11.
- ph_dest_width, 5, destination field width, taken from flit_data[flit_data_width-1 -: ph_dest_width].
- vchannels, 1, number of virtual channels (1..8).
- ports, 5, switch output directions.
- fifo_length, 4, FIFO depth per VC (>=2). The route stage adds one more slot.
- num_dests, 1, valid destinations (<= 2**ph_dest_width).
- lookup, {num_dests{5'b0}}, ports*num_dests bits, destination 0 in the MSB slice. Destination d occupies [(num_dests-d)*ports-1 -: ports].

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- link_flit, input, flit_width, incoming flit (flit_width = data+type).
- link_valid, input, vchannels, one-hot: flit valid for VC v.
- link_credit, output, vchannels, 1-cycle pulse per slot freed in VC v.
- switch_request, output, ports*vchannels, per-VC one-hot direction request; VC v uses slice [v*ports +: ports].
- switch_flit, output, flit_width*vchannels, per-VC route-stage flit.
- switch_read, input, ports*vchannels, per-VC grant from the output side.
- err_overflow, output, vchannels, sticky: flit arrived with no free slot.
- err_dest, output, vchannels, 1-cycle pulse: header had destination >= num_dests.

Behaviour:
- Reset (async, rst_n low):
  - FIFOs and stage registers empty; all outputs 0; route state IDLE.
  - Deassertion is synchronised internally (2-flop) before release.
- Credit contract:
  - Upstream starts with fifo_length+1 credits per VC and sends only while holding credit.
  - No input ready signal; the port accepts every valid flit.
- Capacity and overflow:
  - Capacity per VC = fifo_length + 1.
  - A flit arriving at capacity (with no same-cycle departure) is dropped and sets err_overflow[v] until reset.
- Bypass:
  - If the FIFO is empty and the stage is empty, or the stage is being transferred this cycle, the incoming flit loads the stage directly.
  - Bypass latency: link_valid at cycle n gives switch_request at n+1.
  - Otherwise the flit enters the FIFO, and the FIFO head refills the stage the cycle the stage empties.
  - Ordering is preserved within a VC.
- Transfer:
  - Occurs when (switch_read_v & switch_request_v) != 0.
  - Grant bits outside the request vector are ignored.
  - On transfer: link_credit[v] pulses in the next cycle, and the stage reloads the same cycle (back-to-back, 1 flit/cycle sustained).
- Route FSM per VC:
  - IDLE: stage holds HEADER -> dir = lookup slice of dest, go ROUTED.
    - SINGLE is routed the same way and stays IDLE after transfer.
    - PAYLOAD or LAST in IDLE is a protocol error: the flit is discarded with a credit, and err_dest pulses.
  - ROUTED: every flit requests the latched dir. Transfer of LAST -> IDLE.
  - DROP: entered when dest >= num_dests (err_dest pulses once).
    - Flits are consumed internally at 1/cycle with credits returned and switch_request held 0.
    - LAST or SINGLE -> IDLE.
- A lookup slice of all zeros behaves like DROP, with no error pulse.
- switch_flit equals the stage contents whenever the stage is valid; it is 0 when the stage is empty.
- Simultaneous arrival and departure at capacity is legal: no overflow, no credit loss.
- The VCs are fully independent; link_valid with more than one bit set is ignored and flagged as overflow on all of those VCs.

Test Plan:
- Bypass: reset, send SINGLE dest 0 on VC0 (lookup dest0=00100) -> switch_request[4:0]=00100 one cycle later. Grant 00100 -> link_credit[0] pulses next cycle.
- Worm lock: HEADER dest 1 (dir 00010), PAYLOAD, LAST, with grant held -> three consecutive transfers, each requesting 00010. State returns to IDLE, and 3 credits are returned.
- Fill and backpressure: fifo_length=4, no grants, send 5 flits -> all stored. The 6th sets err_overflow[0]=1, and the dropped flit is never requested.
- Simultaneous: at capacity, grant and new flit in the same cycle -> no error, order preserved, exactly 1 credit.
- Bad destination: num_dests=2, HEADER dest 3 + 2 PAYLOAD + LAST -> err_dest one pulse, switch_request stays 0, 4 credits returned.
- Multi-VC: vchannels=2, interleave worms on VC0 and VC1 to different dirs -> independent requests on slices [4:0] and [9:5]. Assert reset mid-worm -> all outputs 0 immediately.
